// File: rtl/pool_relu_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pool_relu_unit_if
//  Description : Stream bundle for pool_relu_unit. Carries the packed 64-bit
//                partial-sum input stream, the packed 64-bit pooled output
//                stream and the end-of-plane pulse.
//                slave  : the pooling unit side.
//                master : the producer / consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface pool_relu_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        plane_done;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output plane_done
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  plane_done
  );
endinterface
`default_nettype wire

// File: rtl/pool_relu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pool_relu_unit
//  Description : Streaming 2x2 / stride-2 signed max-pool over packed words of
//                four 16-bit neurons. Even rows are reduced horizontally and
//                parked in a one-row line buffer; odd rows finish the vertical
//                max, pair up into a 64-bit pooled word and leave through a
//                single-entry output register.
//                Optional feature macro: POOL_RELU_EN clamps negative pooled
//                values to zero before they are loaded into out_data.
//  Revision    : 1.0  initial release
// ============================================================================
module pool_relu_unit #(
  parameter int ROW_WORDS = 4,  // 64-bit words per input row, even, >= 2
  parameter int ROWS      = 8   // rows per plane, even, >= 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pool_relu_unit_if.slave  bus
);

  localparam int COL_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] C_LAST_COL = COL_W'(ROW_WORDS - 1);
  localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(ROWS - 1);

  // Row parity of the word currently being accepted.
  typedef enum logic [0:0] {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [31:0]       stash_q, stash_d;
  logic [63:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;     // held word closes the plane
  logic              plane_done_q, plane_done_d;

  // Line buffer of horizontally pooled even-row pairs {h0,h1}; not reset.
  logic [31:0]       lb_q [ROW_WORDS];
  logic              lb_we;
  logic [31:0]       lb_wdata;
  logic [31:0]       lb_rdata;

  logic              in_ready;
  logic              in_acc;
  logic              out_acc;
  logic              last_col;
  logic              last_row;

  logic signed [15:0] n0, n1, n2, n3;
  logic signed [15:0] h0, h1;
  logic signed [15:0] lb_h0, lb_h1;
  logic signed [15:0] q0, q1;
  logic [63:0]        pooled_word;
  logic [63:0]        pooled_out;

  function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    return (a >= b) ? a : b;
  endfunction

  // Handshake: a full output register blocks all input unless it drains now.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign in_acc   = bus.in_valid && in_ready;
  assign out_acc  = out_valid_q && bus.out_ready;
  assign last_col = (col_q == C_LAST_COL);
  assign last_row = (row_q == C_LAST_ROW);

  // Neuron unpack, n0 is the leftmost column.
  assign n0 = bus.in_data[63:48];
  assign n1 = bus.in_data[47:32];
  assign n2 = bus.in_data[31:16];
  assign n3 = bus.in_data[15:0];

  // Horizontal reduction of adjacent columns.
  assign h0 = smax(n0, n1);
  assign h1 = smax(n2, n3);

  // Vertical reduction against the even row parked at the same column.
  assign lb_rdata = lb_q[col_q];
  assign lb_h0    = lb_rdata[31:16];
  assign lb_h1    = lb_rdata[15:0];
  assign q0       = smax(h0, lb_h0);
  assign q1       = smax(h1, lb_h1);

  // Left pooled pair comes from the stash, right pair from this word.
  assign pooled_word = {stash_q, q0, q1};

  // Per-lane output shaping; pooled values are selected inputs, so no widening.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic signed [15:0] lane;
    assign lane = pooled_word[63-16*g -: 16];
`ifdef POOL_RELU_EN
    assign pooled_out[63-16*g -: 16] = lane[15] ? 16'h0000 : lane;
`else
    assign pooled_out[63-16*g -: 16] = lane;
`endif
  end : g_lane

  // Next-state: counters, row-parity FSM, line buffer write, stash and output.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    stash_d      = stash_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    lb_we        = 1'b0;
    lb_wdata     = {h0, h1};
    plane_done_d = out_acc && out_last_q;

    if (out_acc) begin
      out_valid_d = 1'b0;
    end

    if (in_acc) begin
      col_d = last_col ? '0 : col_q + COL_W'(1);
      if (last_col) begin
        row_d   = last_row ? '0 : row_q + ROW_W'(1);
        state_d = (state_q == S_EVEN) ? S_ODD : S_EVEN;
      end

      case (state_q)
        S_EVEN: begin
          lb_we = 1'b1;
        end
        S_ODD: begin
          if (!col_q[0]) begin
            stash_d = {q0, q1};
          end else begin
            // A reload in the same cycle as a drain keeps out_valid high.
            out_data_d  = pooled_out;
            out_valid_d = 1'b1;
            out_last_d  = last_row && last_col;
          end
        end
        default: begin
          state_d = S_EVEN;
        end
      endcase
    end
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EVEN;
      col_q        <= '0;
      row_q        <= '0;
      stash_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      plane_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      stash_q      <= stash_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      plane_done_q <= plane_done_d;
    end
  end

  // Line buffer storage; contents are always rewritten by an even row first.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[col_q] <= lb_wdata;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.plane_done = plane_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_relu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_relu_unit
//  Description : Self-checking bench for pool_relu_unit. A 2x2 instance runs
//                the hand-computed vectors; a default-size instance runs
//                streaming, backpressure, mid-plane reset and random planes
//                against a plane-level max-pool model.
//                Honours POOL_RELU_EN the same way the design does.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pool_relu_unit;

  localparam int W_A    = 2;
  localparam int H_A    = 2;
  localparam int W_B    = 4;
  localparam int H_B    = 8;
  localparam int WORDS_B = W_B * H_B;
  localparam int OUTS_B = (H_B / 2) * (W_B / 2);
  localparam int BOUND  = 1000;
  localparam int N_RAND = 100;

  localparam logic [63:0] BASIC_EXP = 64'h0005_0002_0008_0006;
`ifdef POOL_RELU_EN
  localparam logic [63:0] NEG_EXP = 64'h0000_0000_0000_0000;
`else
  localparam logic [63:0] NEG_EXP = 64'hFFFB_FFFB_FFFB_FFFB;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pool_relu_unit_if ifa ();
  pool_relu_unit_if ifb ();

  pool_relu_unit #(.ROW_WORDS(W_A), .ROWS(H_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  pool_relu_unit #(.ROW_WORDS(W_B), .ROWS(H_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          out_cnt = 0;
  int          pd_cnt = 0;
  int          rdy_mode = 1;     // 0: hold low, 1: hold high, 2: random
  bit          sender_done;
  logic [63:0] plane_buf [64];
  logic [63:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: plain 2-D max-pool ----------------
  function automatic logic signed [15:0] nrn(input int w, input int r, input int c);
    logic [63:0] wd;
    wd = plane_buf[r * w + c / 4];
    return wd[63 - 16 * (c % 4) -: 16];
  endfunction

  function automatic logic [63:0] model_word(input int w, input int pr, input int k);
    logic [63:0]        res;
    logic signed [15:0] m;
    logic signed [15:0] v;
    int                 pc;
    res = '0;
    for (int l = 0; l < 4; l++) begin
      pc = 4 * k + l;
      m  = nrn(w, 2 * pr, 2 * pc);
      for (int dr = 0; dr < 2; dr++) begin
        for (int dc = 0; dc < 2; dc++) begin
          v = nrn(w, 2 * pr + dr, 2 * pc + dc);
          if (v > m) m = v;
        end
      end
`ifdef POOL_RELU_EN
      if (m < 0) m = 16'sd0;
`endif
      res[63 - 16 * l -: 16] = m;
    end
    return res;
  endfunction

  task automatic push_plane(input int w, input int h);
    for (int pr = 0; pr < h / 2; pr++)
      for (int k = 0; k < w / 2; k++)
        exp_q.push_back(model_word(w, pr, k));
  endtask

  function automatic logic [15:0] rnd_lane();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++)
      plane_buf[i] = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
  endtask

  // ---------------- drivers ----------------
  task automatic send_b(input logic [63:0] d, input int gap);
    int n;
    if (gap > 0) begin
      ifb.in_valid = 1'b0;
      ifb.in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      repeat (gap) @(posedge clk);
      #1;
    end
    ifb.in_valid = 1'b1;
    ifb.in_data  = d;
    n = 0;
    @(negedge clk);
    while (!ifb.in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) chk("b_in_ready_timeout", 64'(ifb.in_ready), 64'd1);
    @(posedge clk);
    #1;
    ifb.in_valid = 1'b0;
  endtask

  task automatic send_a(input logic [63:0] d);
    int n;
    ifa.in_valid = 1'b1;
    ifa.in_data  = d;
    n = 0;
    @(negedge clk);
    while (!ifa.in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) chk("a_in_ready_timeout", 64'(ifa.in_ready), 64'd1);
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0;
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ifb.out_ready = 1'b0;
        1:       ifb.out_ready = 1'b1;
        default: ifb.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  // ---------------- compare process for the default-size instance ----------------
  task automatic monitor();
    bit pd_pend;
    int oidx;
    pd_pend = 1'b0;
    oidx    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pd_pend = 1'b0;
        oidx    = 0;
      end else begin
        if (pd_pend || ifb.plane_done)
          chk("b_plane_done", 64'(ifb.plane_done), 64'(pd_pend));
        if (ifb.plane_done) pd_cnt++;
        pd_pend = 1'b0;
        if (ifb.out_valid && !ifb.out_ready)
          chk("b_in_ready_stall", 64'(ifb.in_ready), 64'd0);
        if (ifb.out_valid && ifb.out_ready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL b_out_data: got %h, expected no output (t=%0t)", ifb.out_data, $time);
          end else begin
            chk("b_out_data", ifb.out_data, exp_q.pop_front());
          end
          oidx++;
          if (oidx == OUTS_B) begin
            oidx    = 0;
            pd_pend = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < BOUND) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_plane_b(input int max_gap);
    int gap;
    for (int i = 0; i < WORDS_B; i++) begin
      gap = (max_gap > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, max_gap)) : 0;
      send_b(plane_buf[i], gap);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          t0;
    int          o0;
    int          p0;
    int          n;
    logic [63:0] held;

    ifa.in_valid  = 1'b0;
    ifa.in_data   = '0;
    ifa.out_ready = 1'b0;
    ifb.in_valid  = 1'b0;
    ifb.in_data   = '0;
    ifb.out_ready = 1'b1;
    rst           = 1'b1;

    fork
      monitor();
      drive_ready();
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values.
    @(negedge clk);
    chk("a_rst_out_valid",  64'(ifa.out_valid),  64'd0);
    chk("a_rst_out_data",   ifa.out_data,        64'd0);
    chk("a_rst_plane_done", 64'(ifa.plane_done), 64'd0);
    chk("a_rst_in_ready",   64'(ifa.in_ready),   64'd1);
    chk("b_rst_out_valid",  64'(ifb.out_valid),  64'd0);
    chk("b_rst_out_data",   ifb.out_data,        64'd0);
    chk("b_rst_plane_done", 64'(ifb.plane_done), 64'd0);
    chk("b_rst_in_ready",   64'(ifb.in_ready),   64'd1);
    @(posedge clk);
    #1;

    // Basic 2x2 plane: model pin and DUT against the literal.
    plane_buf[0] = 64'h0001_0005_FFFD_0002;
    plane_buf[1] = 64'h0007_0000_0000_FFFF;
    plane_buf[2] = 64'h0004_0002_FFF8_FFF7;
    plane_buf[3] = 64'h0003_0008_0006_0006;
    chk("model_basic", model_word(W_A, 0, 0), BASIC_EXP);
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_a(plane_buf[i]);
    @(negedge clk);
    chk("a_basic_valid", 64'(ifa.out_valid), 64'd1);
    chk("a_basic_data",  ifa.out_data,       BASIC_EXP);
    @(negedge clk);
    chk("a_basic_plane_done", 64'(ifa.plane_done), 64'd1);
    chk("a_basic_valid_clr",  64'(ifa.out_valid),  64'd0);
    @(negedge clk);
    chk("a_basic_pd_pulse",   64'(ifa.plane_done), 64'd0);
    @(posedge clk);
    #1;

    // All-negative 2x2 plane.
    for (int i = 0; i < 4; i++) plane_buf[i] = 64'hFFFB_FFFB_FFFB_FFFB;
    chk("model_neg", model_word(W_A, 0, 0), NEG_EXP);
    for (int i = 0; i < 4; i++) send_a(plane_buf[i]);
    @(negedge clk);
    chk("a_neg_valid", 64'(ifa.out_valid), 64'd1);
    chk("a_neg_data",  ifa.out_data,       NEG_EXP);
    @(negedge clk);
    chk("a_neg_plane_done", 64'(ifa.plane_done), 64'd1);
    @(posedge clk);
    #1;

    // Streaming: two back-to-back planes, one word per cycle.
    o0 = out_cnt;
    p0 = pd_cnt;
    t0 = cyc;
    for (int p = 0; p < 2; p++) begin
      fill_random(WORDS_B);
      push_plane(W_B, H_B);
      send_plane_b(0);
    end
    chk("stream_cycles", 64'(cyc - t0), 64'(2 * WORDS_B));
    wait_drain("stream_drain");
    chk("stream_outs",        64'(out_cnt - o0), 64'(2 * OUTS_B));
    chk("stream_plane_dones", 64'(pd_cnt - p0),  64'd2);

    // Backpressure: hold out_ready low once the first word appears.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    fill_random(WORDS_B);
    push_plane(W_B, H_B);
    sender_done = 1'b0;
    fork
      begin
        send_plane_b(0);
        sender_done = 1'b1;
      end
    join_none
    n = 0;
    @(negedge clk);
    while (!ifb.out_valid && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", 64'(ifb.out_valid), 64'd1);
    chk("bp_in_ready",  64'(ifb.in_ready),  64'd0);
    held = ifb.out_data;
    repeat (8) begin
      @(negedge clk);
      chk("bp_data_hold",     ifb.out_data,       held);
      chk("bp_in_ready_hold", 64'(ifb.in_ready),  64'd0);
    end
    rdy_mode = 1;
    n = 0;
    while (!sender_done && n < 4 * BOUND) begin
      @(posedge clk);
      n++;
    end
    chk("bp_sender_done", 64'(sender_done), 64'd1);
    wait_drain("bp_drain");

    // Reset mid-plane with an output pending.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    fill_random(WORDS_B);
    for (int i = 0; i < 6; i++) send_b(plane_buf[i], 0);
    @(negedge clk);
    chk("mid_pending_valid", 64'(ifb.out_valid), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(ifb.out_valid), 64'd0);
    chk("mid_rst_out_data",  ifb.out_data,       64'd0);
    chk("mid_rst_in_ready",  64'(ifb.in_ready),  64'd1);
    rdy_mode = 1;
    @(posedge clk);
    #1;
    fill_random(WORDS_B);
    push_plane(W_B, H_B);
    send_plane_b(0);
    wait_drain("mid_fresh_drain");

    // Random planes with random in_valid gaps and out_ready.
    rdy_mode = 2;
    for (int p = 0; p < N_RAND; p++) begin
      fill_random(WORDS_B);
      push_plane(W_B, H_B);
      send_plane_b(3);
    end
    rdy_mode = 1;
    wait_drain("rand_drain");

    chk("total_plane_done", 64'(pd_cnt),  64'(N_RAND + 4));
    chk("total_outputs",    64'(out_cnt), 64'((N_RAND + 4) * OUTS_B));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
